led_arm_streamer: RTL and testbench

- Downstream of the polar remap stage: reads one angular column of the remapped polar frame from frame memory and serialises it to the arm's APA102-style LED strip.
- One column per angle_tick from the rotation timer.
- One column is NO_ARM_LED pixels at NO_DELTA_INTERVALS angular positions.
- Owns frame-memory read sequencing, SPI bit timing, and tick overrun handling.

---
 rtl/c2p_pkg.sv | 39 +++
 rtl/spi_word_shifter.sv | 72 +++++++
 rtl/led_arm_streamer.sv | 155 +++++++++++++++
 tb/tb_led_arm_streamer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c2p_pkg.sv
// +----------------------------------------------------------------------+
// | c2p_pkg                                                              |
// | Shared constants, FSM encoding and pixel helpers for the LED streamer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package c2p_pkg;

  localparam int NO_ARM_LED         = 32;
  localparam int NO_DELTA_INTERVALS = 180;
  localparam int RGB_SIZE           = 24;

  localparam logic [2:0]  LED_HDR    = 3'b111;
  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  // The strip expects blue first, then green, then red.
  function automatic logic [31:0] led_word(input logic [4:0] bri, input logic [23:0] pix);
    return {LED_HDR, bri, pix[B_MSB:B_LSB], pix[G_MSB:G_LSB], pix[R_MSB:R_LSB]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_word_shifter.sv
// +----------------------------------------------------------------------+
// | spi_word_shifter                                                     |
// | Serialises one 32-bit word MSB first with SCLK_DIV-clk half periods   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_word_shifter #(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  output logic        sclk,
  output logic        sdo,
  output logic        done
);

  localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

  logic [31:0]      shreg;
  logic [4:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             phase_end;

  assign phase_end = active && (cnt == CNT_LAST);
  // Combinational so the next word can be loaded on the very edge sclk falls.
  assign done      = phase_end && sclk && (bit_cnt == 5'd31);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else if (load) begin
      shreg   <= word;
      sdo     <= word[31];
      sclk    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (phase_end) begin
        cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == 5'd31) begin
            active <= 1'b0;
            sdo    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            shreg   <= {shreg[30:0], 1'b0};
            sdo     <= shreg[30];
          end
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_arm_streamer.sv
// +----------------------------------------------------------------------+
// | led_arm_streamer                                                     |
// | Reads one polar column from frame memory and streams it to the strip  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module led_arm_streamer #(
  parameter int         NO_ARM_LED         = c2p_pkg::NO_ARM_LED,
  parameter int         NO_DELTA_INTERVALS = c2p_pkg::NO_DELTA_INTERVALS,
  parameter int         RGB_SIZE           = c2p_pkg::RGB_SIZE,
  parameter int         ADDR_WIDTH         = 13,
  parameter int         SCLK_DIV           = 4,
  parameter logic [4:0] BRIGHTNESS         = 5'h1F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  angle_tick,
  input  logic [7:0]            angle_idx,
  output logic                  pix_rd,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [RGB_SIZE-1:0]   pix_data,
  output logic                  led_sclk,
  output logic                  led_sdo,
  output logic                  busy,
  output logic                  overrun,
  output logic                  idx_err
);

  import c2p_pkg::*;

  localparam int         LED_W     = (NO_ARM_LED > 1) ? $clog2(NO_ARM_LED) : 1;
  localparam logic [8:0] IDX_LIMIT = 9'(NO_DELTA_INTERVALS);

  logic [2:0]            state;
  logic [7:0]            col;
  logic [7:0]            pend_col;
  logic                  pend;
  logic [LED_W-1:0]      led;
  logic [LED_W-1:0]      fetch_led;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  idx_ok;
  logic                  tick_ok;
  logic                  last_led;
  logic                  load;
  logic [31:0]           word;
  logic                  done;

  assign idx_ok     = ({1'b0, angle_idx} < IDX_LIMIT);
  assign tick_ok    = angle_tick && idx_ok;
  assign last_led   = (led == LED_W'(NO_ARM_LED - 1));
  assign fetch_led  = (state == S_START) ? '0 : led + LED_W'(1);
  assign fetch_addr = ADDR_WIDTH'(col) * ADDR_WIDTH'(NO_ARM_LED) + ADDR_WIDTH'(fetch_led);

  // Loads coincide with the shifter's done edge so words follow back to back.
  always_comb begin
    load = 1'b0;
    word = START_WORD;
    case (state)
      S_IDLE:  load = tick_ok;
      S_WAIT: begin
        load = 1'b1;
        word = led_word(BRIGHTNESS, pix_data);
      end
      S_SHIFT: begin
        load = done && last_led;
        word = END_WORD;
      end
      S_END:   load = done && (pend || tick_ok);
      default: load = 1'b0;
    endcase
  end

  spi_word_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .word  (word),
    .sclk  (led_sclk),
    .sdo   (led_sdo),
    .done  (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      col      <= '0;
      pend_col <= '0;
      pend     <= 1'b0;
      led      <= '0;
      pix_rd   <= 1'b0;
      pix_addr <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      idx_err  <= 1'b0;
    end else begin
      pix_rd <= 1'b0;
      if (angle_tick && !idx_ok)
        idx_err <= 1'b1;
      if ((state != S_IDLE) && tick_ok) begin
        if (pend) begin
          overrun <= 1'b1;
        end else begin
          pend     <= 1'b1;
          pend_col <= angle_idx;
        end
      end

      case (state)
        S_IDLE: begin
          if (tick_ok) begin
            col   <= angle_idx;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START, S_SHIFT: begin
          if (done) begin
            if ((state == S_SHIFT) && last_led) begin
              state <= S_END;
            end else begin
              led      <= fetch_led;
              pix_rd   <= 1'b1;
              pix_addr <= fetch_addr;
              state    <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT:  state <= S_SHIFT;
        S_END: begin
          if (done) begin
            // A tick landing on the final edge is started directly rather than parked.
            if (pend) begin
              col   <= pend_col;
              pend  <= 1'b0;
              state <= S_START;
            end else if (tick_ok) begin
              col   <= angle_idx;
              pend  <= 1'b0;
              state <= S_START;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_arm_streamer.sv
// +----------------------------------------------------------------------+
// | tb_led_arm_streamer                                                  |
// | Scoreboard bench: expected words/addresses queued, monitor compares   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_led_arm_streamer;

  localparam int LEDS = 2;
  localparam int DIV  = 4;
  localparam int AW   = 13;

  logic          clk;
  logic          reset;
  logic          angle_tick;
  logic [7:0]    angle_idx;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data;
  logic          led_sclk;
  logic          led_sdo;
  logic          busy;
  logic          overrun;
  logic          idx_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] word_q[$];
  logic [AW-1:0] addr_q[$];
  logic [23:0] mem [0:7];

  led_arm_streamer #(
    .NO_ARM_LED (LEDS),
    .ADDR_WIDTH (AW),
    .SCLK_DIV   (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .angle_tick (angle_tick),
    .angle_idx  (angle_idx),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .led_sclk   (led_sclk),
    .led_sdo    (led_sdo),
    .busy       (busy),
    .overrun    (overrun),
    .idx_err    (idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memory: data valid only in the cycle right after pix_rd.
  always @(posedge clk) begin
    if (pix_rd) pix_data <= mem[pix_addr[2:0]];
    else        pix_data <= 24'hDEAD00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] led_exp(input int c, input int k);
    case ({c[3:0], k[3:0]})
      8'h00: return 32'hFF030201;
      8'h01: return 32'hFF060504;
      8'h10: return 32'hFF332211;
      8'h11: return 32'hFFCCBBAA;
      8'h20: return 32'hFF998877;
      8'h21: return 32'hFFFFEEDD;
      default: return 32'hBAD0BAD0;
    endcase
  endfunction

  task automatic push_frame(input int c);
    word_q.push_back(32'h0000_0000);
    for (int k = 0; k < LEDS; k++) begin
      addr_q.push_back(AW'(c * LEDS + k));
      word_q.push_back(led_exp(c, k));
    end
    word_q.push_back(32'hFFFF_FFFF);
  endtask

  task automatic tick(input logic [7:0] idx);
    @(negedge clk);
    angle_tick = 1'b1;
    angle_idx  = idx;
    @(negedge clk);
    angle_tick = 1'b0;
    angle_idx  = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || word_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= 4000), 32'd0);
    check({name, "_words_left"}, 32'(word_q.size()), 32'd0);
    check({name, "_addrs_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  // Monitor: decodes strip bits on sclk rises and checks phase lengths.
  logic [31:0] rx_word;
  int          rx_bits;
  int          hi_cnt;
  int          lo_cnt;
  bit          lo_valid;
  logic        prev_sclk;
  logic        prev_sdo;

  always @(negedge clk) begin
    if (!reset) begin
      rx_bits   = 0;
      hi_cnt    = 0;
      lo_cnt    = 0;
      lo_valid  = 0;
      prev_sclk = 1'b0;
      prev_sdo  = 1'b0;
    end else begin
      if (pix_rd) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_addr_unexpected: got %0d expected none", pix_addr);
        end else begin
          check("pix_addr", 32'(pix_addr), 32'(addr_q.pop_front()));
        end
      end
      if (led_sclk && !prev_sclk) begin
        if (lo_valid) begin
          checks++;
          if (lo_cnt != DIV && lo_cnt != DIV + 2) begin
            errors++;
            $display("FAIL sclk_low_phase: got %0d expected %0d or %0d", lo_cnt, DIV, DIV + 2);
          end
        end
        check("sdo_stable", 32'(led_sdo), 32'(prev_sdo));
        rx_word = {rx_word[30:0], led_sdo};
        rx_bits++;
        if (rx_bits == 32) begin
          rx_bits = 0;
          if (word_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL word_unexpected: got %h expected none", rx_word);
          end else begin
            check("strip_word", rx_word, word_q.pop_front());
          end
        end
        hi_cnt = 1;
      end else if (led_sclk) begin
        hi_cnt++;
      end else if (prev_sclk) begin
        check("sclk_high_phase", 32'(hi_cnt), 32'(DIV));
        lo_cnt   = 1;
        lo_valid = 1;
      end else begin
        lo_cnt++;
      end
      if (!busy) lo_valid = 0;
      prev_sclk = led_sclk;
      prev_sdo  = led_sdo;
    end
  end

  initial begin
    int  n;
    int  first;
    bit  flag;

    mem[0] = 24'h010203; mem[1] = 24'h040506;
    mem[2] = 24'h112233; mem[3] = 24'hAABBCC;
    mem[4] = 24'h778899; mem[5] = 24'hDDEEFF;
    mem[6] = 24'h123456; mem[7] = 24'h654321;
    rx_word    = '0;
    angle_tick = 1'b0;
    angle_idx  = 8'h00;
    reset      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_pix_rd",   32'(pix_rd),   32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_sclk",     32'(led_sclk), 32'd0);
    check("rst_sdo",      32'(led_sdo),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_idx_err",  32'(idx_err),  32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Framing and timing: column 1.
    push_frame(1);
    tick(8'd1);
    check("busy_after_tick", 32'(busy), 32'd1);
    n = 0;
    first = -1;
    while (busy && n < 3000) begin
      if (led_sclk && first < 0) first = n;
      n++;
      @(negedge clk);
    end
    check("first_rise_delay", 32'(first), 32'd4);
    check("busy_length", 32'(n), 32'd1028);
    wait_idle("frame1");
    check("idle_sclk", 32'(led_sclk), 32'd0);
    check("idle_sdo",  32'(led_sdo),  32'd0);

    // Pending column queued mid-stream.
    push_frame(1);
    tick(8'd1);
    repeat (100) @(negedge clk);
    push_frame(0);
    tick(8'd0);
    flag = 0;
    n = 0;
    while (word_q.size() != 0 && n < 4000) begin
      if (!busy) flag = 1;
      n++;
      @(negedge clk);
    end
    check("pending_busy_dropped", 32'(flag), 32'd0);
    check("pending_overrun", 32'(overrun), 32'd0);
    wait_idle("pending");

    // Overrun: third tick dropped, column 3 never read.
    push_frame(1);
    tick(8'd1);
    repeat (50) @(negedge clk);
    push_frame(2);
    tick(8'd2);
    repeat (50) @(negedge clk);
    tick(8'd3);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_idle("overrun");
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("idx_err_clean", 32'(idx_err), 32'd0);

    // Out-of-range column while idle.
    tick(8'd180);
    check("bad_idx_err",  32'(idx_err), 32'd1);
    check("bad_idx_busy", 32'(busy),    32'd0);
    flag = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix_rd || led_sclk || busy) flag = 1;
    end
    check("bad_idx_quiet", 32'(flag), 32'd0);

    // Asynchronous reset in the middle of an LED word.
    push_frame(2);
    tick(8'd2);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_pix_rd",  32'(pix_rd),   32'd0);
    check("arst_addr",    32'(pix_addr), 32'd0);
    check("arst_sclk",    32'(led_sclk), 32'd0);
    check("arst_sdo",     32'(led_sdo),  32'd0);
    check("arst_busy",    32'(busy),     32'd0);
    check("arst_overrun", 32'(overrun),  32'd0);
    check("arst_idx_err", 32'(idx_err),  32'd0);
    word_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(0);
    tick(8'd0);
    wait_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
